// File: rtl/interrupt_controller_if.sv
// Core-side interrupt handshake bundle between interrupt_controller (master)
// and the program counter (slave).
interface interrupt_controller_if #(
    parameter int ID_WIDTH = 3
);
    logic                interrupt_enable;
    logic [19:0]         interrupt_address;
    logic                interrupt_disable;
    logic [ID_WIDTH-1:0] active_id;
    logic                interrupt_ack;
    logic                interrupt_return;

    modport master (
        output interrupt_enable,
        output interrupt_address,
        output interrupt_disable,
        output active_id,
        input  interrupt_ack,
        input  interrupt_return
    );

    modport slave (
        input  interrupt_enable,
        input  interrupt_address,
        input  interrupt_disable,
        input  active_id,
        output interrupt_ack,
        output interrupt_return
    );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-capturing, masked, lowest-index-first vectored interrupt source for the core.
// Optional INTC_IRQ_SYNC_EN adds a two-flop synchroniser per irq_in bit.
module interrupt_controller #(
    parameter int          NUM_SOURCES  = 8,
    parameter int          ID_WIDTH     = 3,
    parameter logic [19:0] VECTOR_BASE  = 20'h00100,
    parameter int          VECTOR_SHIFT = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic                   global_en,
    input  logic                   mask_wr,
    input  logic [NUM_SOURCES-1:0] mask_data,
    output logic [NUM_SOURCES-1:0] pending,
    interrupt_controller_if.master core
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SERVICE
    } state_t;

    state_t state, state_next;

    logic [NUM_SOURCES-1:0] irq_s;
    logic [NUM_SOURCES-1:0] irq_prev;
    logic [NUM_SOURCES-1:0] irq_rise;
    logic [NUM_SOURCES-1:0] mask;
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] ack_clear;
    logic [NUM_SOURCES-1:0] pending_next;
    logic [ID_WIDTH-1:0]    winner;
    logic                   found;

    logic                   enable_next;
    logic [19:0]            address_next;
    logic                   disable_next;
    logic [ID_WIDTH-1:0]    id_next;

`ifdef INTC_IRQ_SYNC_EN
    logic [NUM_SOURCES-1:0] sync_q1;
    logic [NUM_SOURCES-1:0] sync_q2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = irq_in;
`endif

    assign irq_rise = irq_s & ~irq_prev;
    assign eligible = pending & mask;

    // A fresh edge on the bit being acknowledged must survive the clear.
    assign pending_next = (pending & ~ack_clear) | irq_rise;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (!found && eligible[i]) begin
                winner = ID_WIDTH'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        enable_next  = core.interrupt_enable;
        address_next = core.interrupt_address;
        disable_next = core.interrupt_disable;
        id_next      = core.active_id;
        ack_clear    = '0;
        unique case (state)
            IDLE: begin
                if (global_en && found) begin
                    id_next      = winner;
                    address_next = VECTOR_BASE + (20'(winner) << VECTOR_SHIFT);
                    enable_next  = 1'b1;
                    state_next   = REQUEST;
                end
            end
            REQUEST: begin
                if (core.interrupt_ack) begin
                    ack_clear    = NUM_SOURCES'(1) << core.active_id;
                    enable_next  = 1'b0;
                    disable_next = 1'b0;
                    state_next   = SERVICE;
                end
            end
            SERVICE: begin
                if (core.interrupt_return) begin
                    disable_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            irq_prev               <= '0;
            mask                   <= '1;
            pending                <= '0;
            core.interrupt_enable  <= 1'b0;
            core.interrupt_address <= '0;
            core.interrupt_disable <= 1'b1;
            core.active_id         <= '0;
        end else begin
            state                  <= state_next;
            irq_prev               <= irq_s;
            pending                <= pending_next;
            core.interrupt_enable  <= enable_next;
            core.interrupt_address <= address_next;
            core.interrupt_disable <= disable_next;
            core.active_id         <= id_next;
            if (mask_wr) begin
                mask <= mask_data;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (8 sources, default vectors).
module tb_interrupt_controller;

`ifdef INTC_IRQ_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       global_en;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic [7:0] pending;

    int checks   = 0;
    int failures = 0;

    interrupt_controller_if #(.ID_WIDTH(3)) core_bus ();

    interrupt_controller #(
        .NUM_SOURCES (8),
        .ID_WIDTH    (3),
        .VECTOR_BASE (20'h00100),
        .VECTOR_SHIFT(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .irq_in   (irq_in),
        .global_en(global_en),
        .mask_wr  (mask_wr),
        .mask_data(mask_data),
        .pending  (pending),
        .core     (core_bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One-cycle irq pulse, then wait out any synchroniser delay so pending is visible.
    task automatic pulse_irq(input logic [7:0] bits);
        irq_in = bits;
        tick();
        irq_in = 8'h00;
        repeat (SD) tick();
    endtask

    task automatic do_ack();
        core_bus.interrupt_ack = 1'b1;
        tick();
        core_bus.interrupt_ack = 1'b0;
    endtask

    task automatic do_return();
        core_bus.interrupt_return = 1'b1;
        tick();
        core_bus.interrupt_return = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic [2:0] id, input logic [19:0] addr);
        check({tag, "_en"}, 32'(core_bus.interrupt_enable), 32'd1);
        check({tag, "_id"}, 32'(core_bus.active_id), 32'(id));
        check({tag, "_addr"}, 32'(core_bus.interrupt_address), 32'(addr));
    endtask

    initial begin
        reset                     = 1'b1;
        irq_in                    = 8'hFF;
        global_en                 = 1'b1;
        mask_wr                   = 1'b0;
        mask_data                 = 8'h00;
        core_bus.interrupt_ack    = 1'b0;
        core_bus.interrupt_return = 1'b0;

        // reset
        repeat (2) tick();
        check("rst_en", 32'(core_bus.interrupt_enable), 32'd0);
        check("rst_addr", 32'(core_bus.interrupt_address), 32'h0);
        check("rst_dis", 32'(core_bus.interrupt_disable), 32'd1);
        check("rst_id", 32'(core_bus.active_id), 32'd0);
        check("rst_pend", 32'(pending), 32'h00);
        reset  = 1'b0;
        irq_in = 8'h00;
        tick();
        check("post_rst_en", 32'(core_bus.interrupt_enable), 32'd0);

        // single source 3
        pulse_irq(8'h08);
        check("s3_pend", 32'(pending), 32'h08);
        check("s3_en_early", 32'(core_bus.interrupt_enable), 32'd0);
        tick();
        check_req("s3_req", 3'd3, 20'h0010C);
        do_ack();
        check("s3_ack_pend", 32'(pending), 32'h00);
        check("s3_ack_dis", 32'(core_bus.interrupt_disable), 32'd0);
        check("s3_ack_en", 32'(core_bus.interrupt_enable), 32'd0);
        do_return();
        check("s3_ret_dis", 32'(core_bus.interrupt_disable), 32'd1);

        // priority 1 over 5, stray return while requesting
        pulse_irq(8'h22);
        check("pri_pend", 32'(pending), 32'h22);
        tick();
        check_req("pri_first", 3'd1, 20'h00104);
        do_return();
        check("pri_stray_ret_en", 32'(core_bus.interrupt_enable), 32'd1);
        check("pri_stray_ret_dis", 32'(core_bus.interrupt_disable), 32'd1);
        do_ack();
        check("pri_ack_pend", 32'(pending), 32'h20);
        check("pri_ack_dis", 32'(core_bus.interrupt_disable), 32'd0);
        do_return();
        check("pri_ret_dis", 32'(core_bus.interrupt_disable), 32'd1);
        check("pri_gap_en", 32'(core_bus.interrupt_enable), 32'd0);
        tick();
        check_req("pri_second", 3'd5, 20'h00114);
        do_ack();
        do_return();

        // mask
        mask_wr   = 1'b1;
        mask_data = 8'hFE;
        tick();
        mask_wr = 1'b0;
        pulse_irq(8'h01);
        check("msk_pend", 32'(pending), 32'h01);
        repeat (2) tick();
        check("msk_no_req", 32'(core_bus.interrupt_enable), 32'd0);
        mask_wr   = 1'b1;
        mask_data = 8'hFF;
        tick();
        mask_wr = 1'b0;
        check("msk_wr_edge_en", 32'(core_bus.interrupt_enable), 32'd0);
        tick();
        check_req("msk_req", 3'd0, 20'h00100);
        do_ack();
        do_return();

        // request holds against global_en drop and higher-priority edge
        pulse_irq(8'h10);
        tick();
        check_req("hold_req", 3'd4, 20'h00110);
        global_en = 1'b0;
        pulse_irq(8'h01);
        tick();
        check_req("hold_stable", 3'd4, 20'h00110);
        global_en = 1'b1;
        do_ack();
        check("hold_ack_pend", 32'(pending), 32'h01);

        // no nesting in service
        pulse_irq(8'h04);
        check("nest_pend", 32'(pending), 32'h05);
        check("nest_en", 32'(core_bus.interrupt_enable), 32'd0);
        tick();
        check("nest_en2", 32'(core_bus.interrupt_enable), 32'd0);
        do_return();
        check("nest_ret_en", 32'(core_bus.interrupt_enable), 32'd0);
        tick();
        check_req("nest_next", 3'd0, 20'h00100);
        do_ack();
        do_return();
        tick();
        check_req("nest_b2", 3'd2, 20'h00108);

        // set wins over ack-clear on the same bit
        irq_in = 8'h04;
        repeat (SD) tick();
        do_ack();
        irq_in = 8'h00;
        check("setwin_pend", 32'(pending), 32'h04);
        check("setwin_dis", 32'(core_bus.interrupt_disable), 32'd0);
        do_return();
        tick();
        check_req("setwin_again", 3'd2, 20'h00108);
        do_ack();
        check("setwin_clr", 32'(pending), 32'h00);
        do_return();

        // reset mid-service
        pulse_irq(8'h01);
        tick();
        check_req("rms_req", 3'd0, 20'h00100);
        do_ack();
        pulse_irq(8'h30);
        check("rms_pend", 32'(pending), 32'h30);
        check("rms_dis0", 32'(core_bus.interrupt_disable), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rms_pend0", 32'(pending), 32'h00);
        check("rms_dis", 32'(core_bus.interrupt_disable), 32'd1);
        check("rms_addr", 32'(core_bus.interrupt_address), 32'h0);
        repeat (3) tick();
        check("rms_no_req", 32'(core_bus.interrupt_enable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
